// File: rtl/fir_lms_gen_pkg.sv
// Shared definitions for the adaptive LMS FIR filter.
// Holds the default widths, the controller state encoding, the saturating clamp
// used on every arithmetic result, and the log2 helper that sizes the accumulator.
package fir_lms_gen_pkg;

    localparam int W1_DEF    = 8;   // data / coefficient width
    localparam int W2_DEF    = 16;  // product / output / error width
    localparam int L_DEF     = 4;   // number of taps
    localparam int FRAC_DEF  = 7;   // fraction bits of x and f
    localparam int MU_SH_DEF = 1;   // mu = 2^-(MU_SH+1)

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        ACC  = 2'd2
    } state_t;

    // Number of bits needed to count n items (ceil(log2(n))).
    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int v = 1; v < n; v = v * 2) begin
            r = r + 1;
        end
        return r;
    endfunction

    // Clamp a signed value to the range of a w-bit two's complement number.
    function automatic logic signed [31:0] sat(input logic signed [31:0] v, input int w);
        logic signed [31:0] hi;
        logic signed [31:0] lo;
        hi = (32'sd1 <<< (w - 1)) - 32'sd1;
        lo = -hi - 32'sd1;
        if (v > hi) begin
            return hi;
        end else if (v < lo) begin
            return lo;
        end else begin
            return v;
        end
    endfunction

endpackage

// File: rtl/fir_lms_gen_if.sv
// Sample/result bus of the LMS FIR filter.
// master: sample source / result consumer (drives x_in, d_in, in_valid, adapt).
// slave : the filter (drives in_ready, y_out, e_out, out_valid, f_out).
// f_out packs coefficient i into bits [i*W1 +: W1].
interface fir_lms_gen_if
    import fir_lms_gen_pkg::*;
#(
    parameter int W1 = W1_DEF,
    parameter int W2 = W2_DEF,
    parameter int L  = L_DEF
);
    logic signed [W1-1:0] x_in;
    logic signed [W1-1:0] d_in;
    logic                 in_valid;
    logic                 in_ready;
    logic                 adapt;
    logic signed [W2-1:0] y_out;
    logic signed [W2-1:0] e_out;
    logic                 out_valid;
    logic [L*W1-1:0]      f_out;

    modport master (
        output x_in, d_in, in_valid, adapt,
        input  in_ready, y_out, e_out, out_valid, f_out
    );

    modport slave (
        input  x_in, d_in, in_valid, adapt,
        output in_ready, y_out, e_out, out_valid, f_out
    );
endinterface

// File: rtl/fir_lms_gen_tap.sv
// One LMS tap cell (the lms_tap slice of the filter).
// Holds one coefficient f and the registered product p = x*f. On upd_en the
// coefficient moves by (x*emu) >>> W1, truncated to W1, with a saturating add.
// Ports: clk, reset (sync, active-high), x (tap sample), emu (scaled error),
//        mul_en (register product), upd_en (apply update), p, f.
module fir_lms_gen_tap
    import fir_lms_gen_pkg::*;
#(
    parameter int W1 = W1_DEF,
    parameter int W2 = W2_DEF
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic signed [W1-1:0] x,
    input  logic signed [W1-1:0] emu,
    input  logic                 mul_en,
    input  logic                 upd_en,
    output logic signed [W2-1:0] p,
    output logic signed [W1-1:0] f
);

    logic signed [W2-1:0] x_ext_s;
    logic signed [W2-1:0] f_ext_s;
    logic signed [W2-1:0] emu_ext_s;
    logic signed [W2-1:0] xe_s;
    logic signed [W1-1:0] upd_s;
    logic signed [W1:0]   f_sum_s;
    logic signed [W1-1:0] f_new_s;
    logic signed [W2-1:0] p_r;
    logic signed [W1-1:0] f_r;

    // Product, update step and saturated next coefficient.
    always_comb begin
        x_ext_s   = {{(W2-W1){x[W1-1]}}, x};
        f_ext_s   = {{(W2-W1){f_r[W1-1]}}, f_r};
        emu_ext_s = {{(W2-W1){emu[W1-1]}}, emu};
        // Both operands are W1 wide, so the true product always fits in W2.
        xe_s      = x_ext_s * emu_ext_s;
        upd_s     = W1'(xe_s >>> W1);
        f_sum_s   = {f_r[W1-1], f_r} + {upd_s[W1-1], upd_s};
        f_new_s   = W1'(sat(32'(f_sum_s), W1));
    end

    // Product and coefficient registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            p_r <= {W2{1'b0}};
            f_r <= {W1{1'b0}};
        end else begin
            if (mul_en) begin
                p_r <= x_ext_s * f_ext_s;
            end
            if (upd_en) begin
                f_r <= f_new_s;
            end
        end
    end

    assign p = p_r;
    assign f = f_r;

endmodule

// File: rtl/fir_lms_gen.sv
// Parametrised adaptive LMS FIR filter, one sample per 3-cycle transaction.
// IDLE accepts a sample (shifting the tap line), MUL registers the tap products,
// ACC forms y/e, pulses out_valid and, when adapt is high, updates coefficients.
// Ports: clk, reset (sync, active-high), bus (fir_lms_gen_if.slave).
module fir_lms_gen
    import fir_lms_gen_pkg::*;
#(
    parameter int W1    = W1_DEF,
    parameter int W2    = W2_DEF,
    parameter int L     = L_DEF,
    parameter int FRAC  = FRAC_DEF,
    parameter int MU_SH = MU_SH_DEF
) (
    input  logic         clk,
    input  logic         reset,
    fir_lms_gen_if.slave bus
);

    // Accumulator wide enough that L full-width products cannot overflow.
    localparam int AW = W2 + clog2(L);

    state_t               state_r;
    logic signed [W1-1:0] x_r [L];
    logic signed [W1-1:0] d_r;
    logic signed [W2-1:0] y_r;
    logic signed [W2-1:0] e_r;
    logic                 out_valid_r;
    logic                 in_ready_r;

    logic signed [W2-1:0] p_s [L];
    logic signed [W1-1:0] f_s [L];
    logic signed [AW-1:0] sum_s;
    logic signed [AW:0]   diff_s;
    logic signed [W2-1:0] y_s;
    logic signed [W2-1:0] e_s;
    logic signed [W1-1:0] emu_s;
    logic [L*W1-1:0]      f_pack_s;
    logic                 mul_en_s;
    logic                 upd_en_s;

    assign mul_en_s = (state_r == MUL);
    assign upd_en_s = (state_r == ACC) && bus.adapt;

    for (genvar i = 0; i < L; i++) begin : g_tap
        fir_lms_gen_tap #(.W1(W1), .W2(W2)) u_tap (
            .clk    (clk),
            .reset  (reset),
            .x      (x_r[i]),
            .emu    (emu_s),
            .mul_en (mul_en_s),
            .upd_en (upd_en_s),
            .p      (p_s[i]),
            .f      (f_s[i])
        );
    end

    // Adder tree, scaled error and step-size-weighted error.
    always_comb begin
        sum_s = {AW{1'b0}};
        for (int i = 0; i < L; i++) begin
            sum_s = sum_s + AW'(p_s[i]);
        end
        diff_s = (AW+1)'(d_r) - (AW+1)'(sum_s >>> FRAC);
        y_s    = W2'(sat(32'(sum_s), W2));
        e_s    = W2'(sat(32'(diff_s), W2));
        emu_s  = W1'(sat(32'(e_s >>> MU_SH), W1));
    end

    // Pack the coefficient registers for f_out.
    always_comb begin
        f_pack_s = {(L*W1){1'b0}};
        for (int i = 0; i < L; i++) begin
            f_pack_s[i*W1 +: W1] = f_s[i];
        end
    end

    // Transaction controller, tap line and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= IDLE;
            for (int i = 0; i < L; i++) begin
                x_r[i] <= {W1{1'b0}};
            end
            d_r         <= {W1{1'b0}};
            y_r         <= {W2{1'b0}};
            e_r         <= {W2{1'b0}};
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
        end else begin
            case (state_r)
                IDLE: begin
                    out_valid_r <= 1'b0;
                    if (bus.in_valid) begin
                        for (int i = L - 1; i > 0; i--) begin
                            x_r[i] <= x_r[i-1];
                        end
                        x_r[0]     <= bus.x_in;
                        d_r        <= bus.d_in;
                        in_ready_r <= 1'b0;
                        state_r    <= MUL;
                    end
                end
                MUL: begin
                    out_valid_r <= 1'b0;
                    state_r     <= ACC;
                end
                ACC: begin
                    y_r         <= y_s;
                    e_r         <= e_s;
                    out_valid_r <= 1'b1;
                    in_ready_r  <= 1'b1;
                    state_r     <= IDLE;
                end
                default: begin
                    out_valid_r <= 1'b0;
                    in_ready_r  <= 1'b1;
                    state_r     <= IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_r;
    assign bus.y_out     = y_r;
    assign bus.e_out     = e_r;
    assign bus.out_valid = out_valid_r;
    assign bus.f_out     = f_pack_s;

endmodule

// File: tb/tb_fir_lms_gen.sv
// Self-checking bench for fir_lms_gen: a transaction-level LMS model tracks
// taps, coefficients and expected outputs; a per-cycle compare process checks
// the DUT against it, and directed scenarios pin the model with literals.
module tb_fir_lms_gen;

    localparam int W1    = 8;
    localparam int W2    = 16;
    localparam int L     = 4;
    localparam int FRAC  = 7;
    localparam int MU_SH = 1;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    fir_lms_gen_if #(.W1(W1), .W2(W2), .L(L)) bus ();

    fir_lms_gen #(.W1(W1), .W2(W2), .L(L), .FRAC(FRAC), .MU_SH(MU_SH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic int satv(input int v, input int w);
        int hi;
        int lo;
        hi = (1 <<< (w - 1)) - 1;
        lo = -(1 <<< (w - 1));
        return (v > hi) ? hi : ((v < lo) ? lo : v);
    endfunction

    // Behavioural model state
    int mx [L];
    int mf [L];
    int pf [L];
    int py, pe;
    int cnt = 0;        // cycles until the pending result appears (0 = ready)
    int ey = 0, ee = 0, ev = 0;
    int model_ok = 0;
    int ov_count = 0;

    // Model: a sample is accepted when idle and valid; results appear two edges later.
    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < L; i++) begin
                mx[i] = 0;
                mf[i] = 0;
            end
            cnt = 0; ev = 0; ey = 0; ee = 0;
            model_ok = 1;
        end else if (cnt == 0) begin
            ev = 0;
            if (bus.in_valid) begin
                int sum, emu, u;
                logic signed [W1-1:0] u8;
                for (int i = L - 1; i > 0; i--) mx[i] = mx[i-1];
                mx[0] = int'(bus.x_in);
                sum = 0;
                for (int i = 0; i < L; i++) sum += mx[i] * mf[i];
                py  = satv(sum, W2);
                pe  = satv(int'(bus.d_in) - (sum >>> FRAC), W2);
                emu = satv(pe >>> MU_SH, W1);
                for (int i = 0; i < L; i++) begin
                    u     = (mx[i] * emu) >>> W1;
                    u8    = u[W1-1:0];
                    pf[i] = satv(mf[i] + int'(u8), W1);
                end
                cnt = 2;
            end
        end else if (cnt == 2) begin
            cnt = 1;
            ev  = 0;
        end else begin
            cnt = 0;
            ev  = 1;
            ey  = py;
            ee  = pe;
            if (bus.adapt) begin
                for (int i = 0; i < L; i++) mf[i] = pf[i];
            end
        end
    end

    // Compare process: every cycle, away from the active edge.
    always @(negedge clk) begin
        if (bus.out_valid === 1'b1) ov_count++;
        if (model_ok != 0) begin
            chk("out_valid", int'(bus.out_valid), ev);
            chk("in_ready", int'(bus.in_ready), (cnt == 0) ? 1 : 0);
            chk("y_out", int'(bus.y_out), ey);
            chk("e_out", int'(bus.e_out), ee);
            for (int i = 0; i < L; i++) begin
                chk("f_out", int'($signed(bus.f_out[i*W1 +: W1])), mf[i]);
            end
        end
    end

    task automatic do_reset();
        reset = 1'b1;
        bus.in_valid = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    // One transfer from idle, checking the transfer-to-out_valid latency.
    task automatic xfer(input int x, input int d, input logic a);
        int n;
        bus.x_in = 8'(x);
        bus.d_in = 8'(d);
        bus.adapt = a;
        bus.in_valid = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        n = 0;
        while (bus.out_valid !== 1'b1 && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk("latency", n, 2);
    endtask

    initial begin
        int c0, f0, prev, e;
        reset = 1'b1;
        bus.in_valid = 1'b0;
        bus.x_in = 8'sd0;
        bus.d_in = 8'sd0;
        bus.adapt = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_y", int'(bus.y_out), 0);
        chk("rst_e", int'(bus.e_out), 0);
        chk("rst_valid", int'(bus.out_valid), 0);
        chk("rst_ready", int'(bus.in_ready), 1);
        chk("rst_f", int'(bus.f_out), 0);
        reset = 1'b0;

        // Freeze: coefficients stay at zero
        xfer(64, 32, 1'b0);
        chk("freeze_y", int'(bus.y_out), 0);
        chk("freeze_e", int'(bus.e_out), 32);
        chk("freeze_f", int'(bus.f_out), 0);

        // Single update from reset: f[0] = (64*16) >>> 8 = 4
        do_reset();
        xfer(64, 32, 1'b1);
        chk("upd_e", int'(bus.e_out), 32);
        @(negedge clk);
        chk("upd_f", int'(bus.f_out), 4);

        // Backpressure: in_valid held for 30 edges -> 10 accepted samples
        do_reset();
        c0 = ov_count;
        bus.adapt = 1'b1;
        bus.in_valid = 1'b1;
        bus.x_in = 8'($urandom_range(0, 255));
        bus.d_in = 8'($urandom_range(0, 255));
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            bus.x_in = 8'($urandom_range(0, 255));
            bus.d_in = 8'($urandom_range(0, 255));
        end
        bus.in_valid = 1'b0;
        repeat (4) @(negedge clk);
        chk("bp_pulses", ov_count - c0, 10);

        // Randomised traffic
        for (int k = 0; k < 400; k++) begin
            bus.in_valid = 1'($urandom_range(0, 1));
            bus.adapt    = 1'($urandom_range(0, 1));
            bus.x_in     = 8'($urandom_range(0, 255));
            bus.d_in     = 8'($urandom_range(0, 255));
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        repeat (4) @(negedge clk);

        // Convergence: 500 samples of x = d = 127
        do_reset();
        bus.adapt = 1'b1;
        bus.x_in = 8'sd127;
        bus.d_in = 8'sd127;
        bus.in_valid = 1'b1;
        prev = 0;
        for (int k = 0; k < 1500; k++) begin
            @(negedge clk);
            f0 = int'($signed(bus.f_out[W1-1:0]));
            chk("conv_f0_nondecr", (f0 >= prev) ? 1 : 0, 1);
            chk("conv_f0_range", (f0 >= 0 && f0 <= 127) ? 1 : 0, 1);
            prev = f0;
        end
        bus.in_valid = 1'b0;
        repeat (3) @(negedge clk);
        e = int'(bus.e_out);
        chk("conv_abs_e", (e >= -5 && e <= 5) ? 1 : 0, 1);
        chk("conv_e", e, 3);
        chk("conv_f", int'(bus.f_out), 32'h030F2645);

        // Reset while in MUL: sample discarded, taps and coefficients cleared
        c0 = ov_count;
        bus.x_in = 8'sd50;
        bus.d_in = 8'sd10;
        bus.in_valid = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        chk("mid_valid", int'(bus.out_valid), 0);
        chk("mid_ready", int'(bus.in_ready), 1);
        chk("mid_f", int'(bus.f_out), 0);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        chk("mid_no_pulse", ov_count - c0, 0);
        xfer(64, 32, 1'b1);
        chk("mid_after_y", int'(bus.y_out), 0);
        chk("mid_after_e", int'(bus.e_out), 32);
        @(negedge clk);
        chk("mid_after_f", int'(bus.f_out), 4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
